// File: rtl/spi_frame_slave.sv
// SPI frame slave running in the system clk domain: synchronises sck/sdi/load,
// deserialises a request frame and serialises the core's response back out.
module spi_frame_slave #(
  parameter int IN_W        = 256,
  parameter int OUT_W       = 128,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  output logic             sdo,
  input  logic             load,
  output logic             done,
  output logic [IN_W-1:0]  rx_data,
  output logic             rx_valid,
  input  logic [OUT_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             frame_err,
  output logic             busy
);

  localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam int CNT_W = $clog2(MAX_W + 2);
  localparam logic [CNT_W-1:0] CNT_IN      = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   sck_d;
  logic                   load_d;
  logic [CNT_W-1:0]       cnt;
  logic [IN_W-1:0]        rx_shift;
  logic [OUT_W-2:0]       tx_shift;
  logic                   first_shift;

  logic sck_s, sdi_s, load_s;
  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, load_rise, load_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      sck_d     <= 1'b0;
      load_d    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      sck_d     <= sck_s;
      load_d    <= load_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];
  assign load_s = load_sync[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign lead_edge   = (CPOL == 0) ? sck_rise : sck_fall;
  assign trail_edge  = (CPOL == 0) ? sck_fall : sck_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign load_rise   = load_s & ~load_d;
  assign load_fall   = ~load_s & load_d;

  // A load rise in WAIT is an abort, so the handshake must not complete then.
  assign tx_ready = (state == WAIT) && tx_valid && !load_rise;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      sdo         <= 1'b0;
      done        <= 1'b0;
      first_shift <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (load_rise) begin
            cnt   <= '0;
            state <= RX;
          end
        end
        RX: begin
          if (load_rise) begin
            cnt <= '0;
          end else if (load_fall) begin
            if (cnt == CNT_IN) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              state    <= WAIT;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[IN_W-2:0], sdi_s};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (load_rise) begin
            frame_err <= 1'b1;
            done      <= 1'b0;
            sdo       <= 1'b0;
            cnt       <= '0;
            state     <= RX;
          end else if (tx_valid) begin
            tx_shift    <= tx_data[OUT_W-2:0];
            sdo         <= tx_data[OUT_W-1];
            done        <= 1'b1;
            cnt         <= '0;
            first_shift <= (CPHA != 0);
            state       <= TX;
          end
        end
        TX: begin
          if (load_rise) begin
            frame_err <= 1'b1;
            done      <= 1'b0;
            sdo       <= 1'b0;
            cnt       <= '0;
            state     <= RX;
          end else if (shift_edge) begin
            // With CPHA=1 the first shift edge is the one that presents the MSB.
            if (first_shift) begin
              first_shift <= 1'b0;
            end else begin
              sdo      <= tx_shift[OUT_W-2];
              tx_shift <= {tx_shift[OUT_W-3:0], 1'b0};
            end
          end else if (sample_edge) begin
            if (cnt == CNT_TX_LAST) begin
              done  <= 1'b0;
              sdo   <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: one instance per SPI mode, driven by an
// MCU-style bit-banging model on its own sck/load pins.
module tb_spi_frame_slave;
  localparam int IN_W  = 256;
  localparam int OUT_W = 128;
  localparam int H     = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       sck, load, tx_valid;
  logic             sdi;
  logic [3:0]       sdo, done, rx_valid, tx_ready, frame_err, busy;
  logic [IN_W-1:0]  rx_data [4];
  logic [OUT_W-1:0] tx_data;

  int checks = 0;
  int errors = 0;
  int rxv_n [4] = '{default: 0};
  int ferr_n[4] = '{default: 0};
  int txr_n [4] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_frame_slave #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) dut (
      .clk(clk), .reset(reset), .sck(sck[g]), .sdi(sdi), .sdo(sdo[g]),
      .load(load[g]), .done(done[g]), .rx_data(rx_data[g]),
      .rx_valid(rx_valid[g]), .tx_data(tx_data), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .frame_err(frame_err[g]), .busy(busy[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rxv_n[i]  += int'(rx_valid[i]);
      ferr_n[i] += int'(frame_err[i]);
      txr_n[i]  += int'(tx_ready[i]);
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic sck_cycle(input int m, input bit dout, output bit din);
    bit cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    if (!cpha) begin
      sdi = dout;
      half();
      sck[m] = ~cpol;
      din = sdo[m];
      half();
      sck[m] = cpol;
    end else begin
      sck[m] = ~cpol;
      sdi = dout;
      half();
      sck[m] = cpol;
      din = sdo[m];
      half();
    end
  endtask

  task automatic begin_frame(input int m);
    load[m] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_in(input int m, input logic [IN_W-1:0] d, input int n);
    bit b;
    for (int i = 0; i < n; i++) sck_cycle(m, d[IN_W-1-i], b);
  endtask

  task automatic end_frame(input int m);
    half();
    load[m] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic recv(input int m, input int n, output logic [OUT_W-1:0] got);
    bit b;
    got = '0;
    for (int i = 0; i < n; i++) begin
      sck_cycle(m, 1'b0, b);
      got = {got[OUT_W-2:0], b};
    end
    half();
  endtask

  task automatic offer(input int m, input logic [OUT_W-1:0] d);
    int k;
    k = 0;
    tx_data = d;
    tx_valid[m] = 1'b1;
    while (!done[m] && k < 50) begin
      @(negedge clk);
      k++;
    end
    tx_valid[m] = 1'b0;
    chk($sformatf("m%0d_tx_wait", m), k < 50, 1);
  endtask

  logic [127:0]     pt   = 128'h00112233445566778899aabbccddeeff;
  logic [127:0]     key  = 128'h0f0e0d0c0b0a09080706050403020100;
  logic [OUT_W-1:0] resp = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  logic [IN_W-1:0]  frame1, frame2;
  logic [OUT_W-1:0] got;
  int b_rx, b_fe, b_tr;

  initial begin
    frame1   = {pt, key};
    frame2   = ~frame1;
    reset    = 1'b1;
    sck      = 4'b1100;
    load     = 4'b0000;
    sdi      = 1'b0;
    tx_valid = 4'b0000;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_rst_rx_data", m), rx_data[m], 0);
      chk($sformatf("m%0d_rst_outs", m),
          {sdo[m], done[m], busy[m], rx_valid[m], frame_err[m], tx_ready[m]}, 0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Full request/response in every mode.
    for (int m = 0; m < 4; m++) begin
      b_rx = rxv_n[m]; b_fe = ferr_n[m]; b_tr = txr_n[m];
      begin_frame(m);
      shift_in(m, frame1, IN_W);
      end_frame(m);
      chk($sformatf("m%0d_rx_valid_cnt", m), rxv_n[m] - b_rx, 1);
      chk($sformatf("m%0d_rx_data", m), rx_data[m], frame1);
      chk($sformatf("m%0d_no_err", m), ferr_n[m] - b_fe, 0);
      chk($sformatf("m%0d_busy_wait", m), busy[m], 1);
      offer(m, resp);
      chk($sformatf("m%0d_tx_ready_cnt", m), txr_n[m] - b_tr, 1);
      chk($sformatf("m%0d_done_set", m), done[m], 1);
      chk($sformatf("m%0d_sdo_msb", m), sdo[m], resp[OUT_W-1]);
      recv(m, OUT_W, got);
      chk($sformatf("m%0d_tx_data", m), got, resp);
      repeat (5) @(negedge clk);
      chk($sformatf("m%0d_done_clr", m), done[m], 0);
      chk($sformatf("m%0d_idle", m), busy[m], 0);
    end

    // Short frame of 255 bits.
    b_rx = rxv_n[0]; b_fe = ferr_n[0];
    begin_frame(0);
    shift_in(0, frame2, IN_W - 1);
    end_frame(0);
    chk("short_err", ferr_n[0] - b_fe, 1);
    chk("short_no_valid", rxv_n[0] - b_rx, 0);
    chk("short_rx_hold", rx_data[0], frame1);
    chk("short_idle", busy[0], 0);

    // Abort after 40 response bits, then a full frame.
    begin_frame(0);
    shift_in(0, frame2, IN_W);
    end_frame(0);
    chk("abort_pre_rx", rx_data[0], frame2);
    offer(0, resp);
    recv(0, 40, got);
    chk("abort_40_bits", got[39:0], resp[OUT_W-1:OUT_W-40]);
    b_rx = rxv_n[0]; b_fe = ferr_n[0];
    begin_frame(0);
    chk("abort_err", ferr_n[0] - b_fe, 1);
    chk("abort_done", done[0], 0);
    shift_in(0, frame1, IN_W);
    end_frame(0);
    chk("abort_next_valid", rxv_n[0] - b_rx, 1);
    chk("abort_next_rx", rx_data[0], frame1);

    // Reset at bit 100 of a request.
    begin_frame(0);
    shift_in(0, frame2, 100);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_rx_data", rx_data[0], 0);
    chk("mid_rst_outs", {sdo[0], done[0], busy[0], rx_valid[0], frame_err[0]}, 0);
    load[0] = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    b_rx = rxv_n[0];
    begin_frame(0);
    shift_in(0, frame2, IN_W);
    end_frame(0);
    chk("post_rst_valid", rxv_n[0] - b_rx, 1);
    chk("post_rst_rx", rx_data[0], frame2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
